vaddr_seq_gen: RTL
==================

// Module: vaddr_seq_gen
// PURPOSE
//  Sequential per-element address generator for RVV unit-stride and strided vector loads/stores.
//  Accepts one instruction descriptor (base, stride, width, mop, vl) and streams out element addresses.
//  Emits LANES addresses per beat with a lane mask and a valid/ready handshake to the LSU memory port.
//  Sits between vector decode/operand read and the vector LSU request queue.
// PARAMETERS
//  LANES  4   element addresses per beat (power of 2, 1..16)
//  XLEN   32  address/stride width
//  VL_W   8   width of vl and element-index fields
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous active-high reset
//  cmd_valid  in   1           descriptor valid
//  cmd_ready  out  1           descriptor accepted when valid&ready (high only in IDLE)
//  base       in   XLEN        base address
//  stride     in   XLEN        byte stride (used only when mop==2'b10)
//  width      in   3           EEW code: 000=1B, 101=2B, 110=4B, other=illegal
//  mop        in   2           00=unit-stride, 10=strided, 01/11=unsupported
//  vl         in   VL_W        element count
//  abort      in   1           kill current operation
//  addr_valid out  1           beat valid
//  addr_ready in   1           consumer accepts beat
//  addr       out  LANES*XLEN  lane i address in bits [i*XLEN +: XLEN]
//  lane_mask  out  LANES       lane i active
//  elem_idx   out  VL_W        element index of lane 0 in current beat
//  last       out  1           current beat is final beat
//  done       out  1           one-cycle pulse: operation finished normally
//  err        out  1           one-cycle pulse: illegal width/mop rejected
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; addr_valid, last, done, err=0; addr, lane_mask, elem_idx=0.
//  Step: mop==10 -> step=stride; else unit step from width (1/2/4). Latched at accept.
//  States: IDLE, RUN.
//   IDLE: on cmd_valid&cmd_ready:
//    - mop[0]==1, or width illegal with mop!=10 -> err=1 next cycle, remain IDLE.
//    - vl==0 -> done=1 next cycle, remain IDLE, no beats.
//    - else latch cur=base, idx=0; enter RUN; addr_valid=1 from next cycle (1-cycle latency).
//   RUN: addr[i]=cur+i*step; lane_mask[i]=(idx+i<vl); elem_idx=idx; last=(idx+LANES>=vl).
//    - On addr_valid&addr_ready: cur+=LANES*step; idx+=LANES. If last -> IDLE, done=1 next cycle.
//    - addr_valid&!addr_ready: all beat outputs held stable (no change until accepted).
//  cmd_ready=0 throughout RUN; new descriptors wait.
//  Arithmetic: all address math modulo 2^XLEN; wrap past 2^XLEN-1 is silent; stride is treated unsigned
//   (negative strides work via two's-complement wrap). Computing idx+i uses VL_W+1 bits; no overflow
//   when vl=2^VL_W-1.
//  Masked lanes still carry the computed address (don't-care for consumer); only lane_mask qualifies.
//  abort: in RUN -> IDLE next cycle, addr_valid=0, no done. Abort in the same cycle as a handshake
//   wins: the beat counts as consumed, no further beats, no done. Abort in IDLE is ignored.
//  rst mid-RUN: immediate return to reset values next cycle; the in-flight beat is dropped.
//  done and err never assert together; each is exactly one cycle.
// TESTING
//  1 unit, width=110, base=0x1000, vl=8, ready=1 -> 2 beats: 1000/1004/1008/100C, 1010..101C; mask F,F;
//    last on beat 2; done pulses 1 cycle later.
//  2 strided, stride=0x40, width=000, base=0x200, vl=6 -> beat1 200/240/280/2C0 mask F; beat2 300/340
//    mask 3, last=1.
//  3 backpressure: case 1 with addr_ready low for 3 cycles on beat 1 -> addr/mask/elem_idx stable;
//    beat 2 only after accept.
//  4 wrap/negative: base=0xFFFFFFFC, unit 4B, vl=3 -> FFFFFFFC/00000000/00000004, mask 7.
//    Stride=0xFFFFFFF0 from base 0x100 -> 100/F0/E0/D0.
//  5 vl=0 -> done next cycle, no addr_valid. mop=01 -> err pulse, no beats. width=011 unit -> err.
//  6 abort on beat 1 of vl=16 (with and without simultaneous handshake) -> IDLE next cycle, no done,
//    cmd_ready=1. rst mid-RUN -> all outputs zero next cycle.

Source files
------------

// File: rtl/vaddr_seq_gen.sv
// Per-element address generator for RVV unit-stride and strided vector loads/stores.
// Takes one descriptor (base, stride, width, mop, vl) and streams LANES addresses per beat.
//
// Ports:
//   i_clk, i_rst                        clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready           descriptor handshake (ready only while idle)
//   i_base, i_stride                    base address, byte stride (strided mode only)
//   i_width, i_mop, i_vl                EEW code, addressing mode, element count
//   i_abort                             kill the running operation
//   o_addr_valid / i_addr_ready         beat handshake towards the LSU
//   o_addr                              lane i address in bits [i*XLEN +: XLEN]
//   o_lane_mask, o_elem_idx, o_last     lane qualifiers, lane-0 element index, final beat
//   o_done, o_err                       one-cycle completion / rejection pulses
module vaddr_seq_gen #(
    parameter int LANES = 4,
    parameter int XLEN  = 32,
    parameter int VL_W  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [XLEN-1:0]        i_base,
    input  logic [XLEN-1:0]        i_stride,
    input  logic [2:0]             i_width,
    input  logic [1:0]             i_mop,
    input  logic [VL_W-1:0]        i_vl,
    input  logic                   i_abort,
    output logic                   o_addr_valid,
    input  logic                   i_addr_ready,
    output logic [LANES*XLEN-1:0]  o_addr,
    output logic [LANES-1:0]       o_lane_mask,
    output logic [VL_W-1:0]        o_elem_idx,
    output logic                   o_last,
    output logic                   o_done,
    output logic                   o_err
);

    // One extra bit so idx+lane and idx+LANES never overflow near vl max.
    localparam int IW = VL_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_cur;
    logic [XLEN-1:0]   w_cur_nxt;
    logic [XLEN-1:0]   r_step;
    logic [XLEN-1:0]   w_step_nxt;
    logic [VL_W-1:0]   r_idx;
    logic [VL_W-1:0]   w_idx_nxt;
    logic [VL_W-1:0]   r_vl;
    logic [VL_W-1:0]   w_vl_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic              w_run;
    logic              w_cmd_fire;
    logic              w_beat_fire;
    logic              w_width_ok;
    logic              w_illegal;
    logic [XLEN-1:0]   w_unit_step;
    logic [XLEN-1:0]   w_step_sel;
    logic              w_last;

    assign w_run       = (r_state == S_RUN);
    assign o_cmd_ready = !w_run;
    assign o_addr_valid = w_run;
    assign w_cmd_fire  = i_cmd_valid && o_cmd_ready;
    assign w_beat_fire = o_addr_valid && i_addr_ready;

    always_comb begin
        w_width_ok  = 1'b1;
        w_unit_step = '0;
        case (i_width)
            3'b000:  w_unit_step = XLEN'(1);
            3'b101:  w_unit_step = XLEN'(2);
            3'b110:  w_unit_step = XLEN'(4);
            default: w_width_ok  = 1'b0;
        endcase
    end

    // Strided mode ignores the width code for step purposes, so it is legal there.
    assign w_illegal  = i_mop[0] || (!w_width_ok && (i_mop != 2'b10));
    assign w_step_sel = (i_mop == 2'b10) ? i_stride : w_unit_step;
    assign w_last     = ({1'b0, r_idx} + IW'(LANES)) >= {1'b0, r_vl};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_step  <= '0;
            r_idx   <= '0;
            r_vl    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_step  <= w_step_nxt;
            r_idx   <= w_idx_nxt;
            r_vl    <= w_vl_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_step_nxt  = r_step;
        w_idx_nxt   = r_idx;
        w_vl_nxt    = r_vl;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    if (w_illegal) begin
                        w_err_nxt = 1'b1;
                    end else if (i_vl == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_cur_nxt   = i_base;
                        w_step_nxt  = w_step_sel;
                        w_idx_nxt   = '0;
                        w_vl_nxt    = i_vl;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Abort wins over a simultaneous handshake: beat consumed, no done.
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_beat_fire) begin
                    w_cur_nxt = r_cur + (r_step * XLEN'(LANES));
                    w_idx_nxt = r_idx + VL_W'(LANES);
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Beat outputs depend only on registers, so they stay stable under backpressure.
    always_comb begin
        o_addr      = '0;
        o_lane_mask = '0;
        o_elem_idx  = '0;
        o_last      = 1'b0;
        if (w_run) begin
            o_elem_idx = r_idx;
            o_last     = w_last;
            for (int i = 0; i < LANES; i++) begin
                o_addr[i*XLEN +: XLEN] = r_cur + (XLEN'(i) * r_step);
                o_lane_mask[i] = ({1'b0, r_idx} + IW'(i)) < {1'b0, r_vl};
            end
        end
    end

    assign o_done = r_done;
    assign o_err  = r_err;

endmodule
